// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen
//   Parametrised Fibonacci XNOR LFSR with a rejection-sampling front end that
//   hands out values strictly below a runtime bound over a valid/ready handshake.
//
// Parameters
//   WIDTH  LFSR width, 3..16 (taps come from the maximal-length table below)
//   OUT_W  width of rand_out / bound, 1..WIDTH-1
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   en         advance the LFSR one step
//   load       load seed (priority over en); all-ones seed becomes all-zeros
//   seed       value loaded when load=1
//   bound      exclusive upper bound for results, 0 = unbounded
//   req        request one bounded value (sampled in IDLE only)
//   busy       high while searching or presenting a result
//   out_valid  rand_out holds an accepted value
//   out_ready  consumer accepts rand_out
//   rand_out   accepted random value
//   state      current LFSR state
//   reject_cnt (only with LFSR_REJECT_CNT_EN) saturating count of rejected
//              search cycles, cleared only by reset
//
// Optional feature macro: LFSR_REJECT_CNT_EN
module lfsr_rand_gen #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned OUT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [OUT_W-1:0] bound,
  input  logic             req,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] rand_out,
  output logic [WIDTH-1:0] state
`ifdef LFSR_REJECT_CNT_EN
  ,
  output logic [15:0]      reject_cnt
`endif
);

  // Tap list for a width: bit (t-1) set for each tap t.
  function automatic logic [15:0] tap_list(input int unsigned w);
    logic [15:0] t;
    case (w)
      3:       t = 16'h0006;
      4:       t = 16'h000C;
      5:       t = 16'h0014;
      6:       t = 16'h0030;
      7:       t = 16'h0060;
      8:       t = 16'h00B8;
      9:       t = 16'h0110;
      10:      t = 16'h0240;
      11:      t = 16'h0500;
      12:      t = 16'h0829;
      13:      t = 16'h100D;
      14:      t = 16'h2015;
      15:      t = 16'h6000;
      16:      t = 16'hD008;
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

  localparam logic [15:0] TAPS = tap_list(WIDTH);

  // Tap t reads state[WIDTH-t]; tap-list bit j=t-1 therefore maps to
  // state bit WIDTH-1-j, i.e. the list is bit-reversed across the state.
  function automatic logic [WIDTH-1:0] build_mask();
    logic [WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      m[i] = TAPS[WIDTH-1-i];
    end
    return m;
  endfunction

  localparam logic [WIDTH-1:0] TAP_MASK = build_mask();

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    VALID  = 2'd2
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic             feedback;
  logic [OUT_W-1:0] candidate;
  logic             accept;

  // Reduction XNOR over the taps; untapped bits are masked to 0 and do not
  // change the parity, so all-ones stays the lock-up state.
  assign feedback  = ~^(state & TAP_MASK);
  assign candidate = state[OUT_W-1:0];
  assign accept    = (bound == '0) || (candidate < bound);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= '0;
    end else if (load) begin
      state <= (seed == '1) ? '0 : seed;
    end else if (en) begin
      state <= {feedback, state[WIDTH-1:1]};
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (req)       fsm_d = SEARCH;
      SEARCH:  if (accept)    fsm_d = VALID;
      VALID:   if (out_ready) fsm_d = IDLE;
      default:                fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q    <= IDLE;
      rand_out <= '0;
    end else begin
      fsm_q <= fsm_d;
      if (fsm_q == SEARCH && accept) begin
        rand_out <= candidate;
      end
    end
  end

  assign out_valid = (fsm_q == VALID);
  assign busy      = (fsm_q != IDLE);

`ifdef LFSR_REJECT_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reject_cnt <= '0;
    end else if (fsm_q == SEARCH && !accept && reject_cnt != '1) begin
      reject_cnt <= reject_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Self-checking bench for lfsr_rand_gen (WIDTH=10, OUT_W=4).
// Results are checked by a scoreboard: stimulus pushes the expected rand_out,
// a monitor pops and compares whenever out_valid rises.
module tb_lfsr_rand_gen;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned OUT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] seed = '0;
  logic [OUT_W-1:0] bound = '0;
  logic             req = 1'b0;
  logic             busy;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] rand_out;
  logic [WIDTH-1:0] state;
`ifdef LFSR_REJECT_CNT_EN
  logic [15:0]      reject_cnt;
  int unsigned      exp_rejects = 0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [OUT_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  lfsr_rand_gen #(
    .WIDTH(WIDTH),
    .OUT_W(OUT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .seed      (seed),
    .bound     (bound),
    .req       (req),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rand_out  (rand_out),
    .state     (state)
`ifdef LFSR_REJECT_CNT_EN
    ,
    .reject_cnt(reject_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: compare each newly presented result against the scoreboard.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_unexpected: got rand_out 0x%0h, expected no result", rand_out);
        end else begin
          logic [OUT_W-1:0] e;
          e = exp_q.pop_front();
          if (rand_out !== e) begin
            n_fail++;
            $display("FAIL scoreboard_rand_out: got 0x%0h, expected 0x%0h", rand_out, e);
          end
        end
      end
      prev_valid = out_valid;
`ifdef LFSR_REJECT_CNT_EN
      // SEARCH cycle whose candidate will be rejected at the next edge.
      if (busy && !out_valid && bound != '0 && state[OUT_W-1:0] >= bound)
        exp_rejects++;
`endif
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
`ifdef LFSR_REJECT_CNT_EN
    exp_rejects = 0;
`endif
  endtask

  initial begin
    logic [WIDTH-1:0] seq [0:8];
    int unsigned steps;
    bit saw_ones;
    int unsigned got;
    int unsigned cyc;

    seq[0] = 10'h000; seq[1] = 10'h200; seq[2] = 10'h300; seq[3] = 10'h380;
    seq[4] = 10'h3C0; seq[5] = 10'h3E0; seq[6] = 10'h3F0; seq[7] = 10'h3F8;
    seq[8] = 10'h1FC;

    // Reset values
    #1 reset = 1'b1;
    #3;
    check("reset_state", 32'(state), 32'h0);
    check("reset_rand_out", 32'(rand_out), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;

    // Eight steps from zero
    @(posedge clk);
    #1 en = 1'b1;
    check("seq_0", 32'(state), 32'(seq[0]));
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1 check($sformatf("seq_%0d", i), 32'(state), 32'(seq[i]));
    end
    en = 1'b0;

    // Full period, lock-up value never reached
    do_reset();
    en = 1'b1;
    steps = 0;
    saw_ones = 1'b0;
    do begin
      @(posedge clk);
      #1 steps++;
      if (state == 10'h3FF) saw_ones = 1'b1;
    end while (state != 10'h000 && steps < 1100);
    check("period_len", steps, 32'd1023);
    check("period_no_3ff", 32'(saw_ones), 32'h0);
    en = 1'b0;

    // Load behaviour
    load = 1'b1; seed = 10'h3FF;
    @(posedge clk);
    #1 check("load_ones_to_zero", 32'(state), 32'h0);
    en = 1'b1; seed = 10'h155;
    @(posedge clk);
    #1 check("load_over_en", 32'(state), 32'h155);

    // Handshake, latency and hold: 0x15A steps to 0x0AD, candidate 0xD
    en = 1'b0; seed = 10'h15A;
    @(posedge clk);
    #1 load = 1'b0;
    check("load_15a", 32'(state), 32'h15A);
    en = 1'b1; bound = '0; req = 1'b1; out_ready = 1'b0;
    exp_q.push_back(4'hD);
    @(posedge clk);
    #1 req = 1'b0;
    check("lat_edge1_busy", 32'(busy), 32'h1);
    check("lat_edge1_valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1 check("lat_edge2_valid", 32'(out_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("hold_valid", 32'(out_valid), 32'h1);
      check("hold_rand_out", 32'(rand_out), 32'hD);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'h0);
    check("release_busy", 32'(busy), 32'h0);

    // bound=1: twenty back-to-back requests all return 0
    bound = 4'd1; out_ready = 1'b1; req = 1'b1;
    for (int i = 0; i < 20; i++) exp_q.push_back(4'h0);
    got = 0;
    cyc = 0;
    while (got < 20 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        got++;
        if (got == 20) req = 1'b0;
      end
    end
    check("bound1_results", got, 32'd20);
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bound1_idle", 32'(busy), 32'h0);
    check("scoreboard_drained", exp_q.size(), 32'd0);
`ifdef LFSR_REJECT_CNT_EN
    check("reject_cnt", 32'(reject_cnt), exp_rejects);
`endif

    // Stall in SEARCH (en=0, candidate 5 >= bound 1), then async reset
    en = 1'b0; load = 1'b1; seed = 10'h155; bound = 4'd1;
    @(posedge clk);
    #1 load = 1'b0; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("stall_busy", 32'(busy), 32'h1);
    check("stall_valid", 32'(out_valid), 32'h0);
    #2 reset = 1'b1;
    #1 check("rst_search_busy", 32'(busy), 32'h0);
    check("rst_search_valid", 32'(out_valid), 32'h0);
    check("rst_search_state", 32'(state), 32'h0);
`ifdef LFSR_REJECT_CNT_EN
    check("rst_reject_cnt", 32'(reject_cnt), 32'h0);
    exp_rejects = 0;
`endif
    reset = 1'b0;

    // Async reset while VALID (seed 0x155, unbounded -> result 5)
    @(posedge clk);
    #1 load = 1'b1; seed = 10'h155; bound = '0;
    @(posedge clk);
    #1 load = 1'b0; req = 1'b1;
    exp_q.push_back(4'h5);
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1 check("valid_before_rst", 32'(out_valid), 32'h1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check("rst_valid_valid", 32'(out_valid), 32'h0);
    check("rst_valid_busy", 32'(busy), 32'h0);
    check("rst_valid_state", 32'(state), 32'h0);
    check("rst_valid_rand_out", 32'(rand_out), 32'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    check("final_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
